fit_1d_scheduler: RTL and testbench
===================================

# fit_1d_scheduler

Interleaving scheduler that feeds the out-of-order 1D curve-fitting predictor from up to NUM_STREAMS independent data streams. It keeps three reconstructed predecessors per stream, drives them into the predictor's proceed inputs, and tracks in-flight elements through the fixed PE_LATENCY pipeline. When a result returns, it writes it back into that stream's history. One element is issued per cycle, and the same stream is never reissued until its previous result has been written back.

## Interface
- DATA_W, 32, sample/prediction width (IEEE single).
- CODE_W, 2, predictor code width (00 unpredictable, 01 model0, 10 model1, 11 model2).
- NUM_STREAMS, 48, number of interleaved streams; must be ≥ PE_LATENCY+1 to sustain one issue per cycle.
- SID_W, 6, stream-id width; must satisfy 2^SID_W ≥ NUM_STREAMS.
- PE_LATENCY, 44, cycles from pe_* issue to valid pe_prediction/pe_code/pe_real_error.
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input element offered.
- in_ready  out  1  element accepted when in_valid & in_ready.
- in_stream  in  SID_W  stream id of offered element.
- in_first  in  1  element starts a new stream; clears history and warm-up count.
- in_data  in  DATA_W  sample.
- pe_data_in  out  DATA_W  to predictor data_in.
- pe_proceed1/2/3  out  DATA_W each  to predictor proceed1..3 (oldest..newest).
- pe_code  in  CODE_W  predictor data_out.
- pe_prediction  in  DATA_W  predictor prediction (reconstructed value).
- pe_real_error  in  DATA_W  predictor real_error.
- out_valid  out  1  one-cycle result pulse; no backpressure.
- out_stream  out  SID_W  stream of result.
- out_code  out  CODE_W  final code.
- out_value  out  DATA_W  reconstructed value written to history.
- out_error  out  DATA_W  real error (0 during warm-up).

## Operation
- Per-stream state: hist1, hist2, hist3 (DATA_W each), cnt (2-bit, saturates at 3), busy.
- in_ready = ~busy[in_stream] & ~rst. It is combinational from state only and never depends on in_valid.
- Accept cycle:
  - Register pe_data_in = in_data.
  - Register pe_proceed1/2/3 = hist1/2/3 of in_stream, or all 0 if in_first.
  - Set busy[in_stream].
  - If in_first: clear hist1..3 and cnt of that stream in the same edge.
- Tag pipeline: PE_LATENCY stages carry {valid, stream, in_data, warm}. warm = (cnt < 3) evaluated after any in_first clear.
- Writeback when the tag valid emerges, aligned with the pe_* result inputs:
  - Reconstructed value v = warm ? tag data : pe_prediction.
  - Code c = warm ? 00 : pe_code.
  - Shift history: hist1←hist2, hist2←hist3, hist3←v.
  - cnt ← min(cnt+1, 3).
  - Clear busy.
  - Register out_* on the same edge.
- No cycle is idle-issued. Cycles without an accept send a bubble: tag valid=0 and pe_* hold their last values.
- Accept and writeback in the same cycle always target different streams, because the writeback stream is still busy. Both updates happen in that cycle.
- in_first on a stream that is not busy but has history discards that history. in_first on a busy stream is impossible because in_ready is low.

## Timing
- Reset (asynchronous, active-high):
  - out_valid, out_stream, out_code, out_value, out_error = 0.
  - pe_* = 0.
  - All hist = 0, cnt = 0, busy = 0, tag pipeline cleared.
  - In-flight results are discarded; nothing is emitted for them after release.
- Accept at edge t. pe_* are valid after edge t. The result is sampled at edge t+PE_LATENCY. out_valid is high for the cycle after that edge. Total in→out latency is PE_LATENCY+1.
- Same-stream reissue: earliest new accept is at edge t+PE_LATENCY+1. in_ready for that stream is low between those edges.
- Full throughput: NUM_STREAMS streams issued round-robin accept every cycle with zero stalls.
- out_valid is at most one pulse per cycle. Results return in issue order.

## Test plan
- Warm-up:
  - Stimulus: stream 0, in_first=1, data 1.0, 2.0, 3.0, 4.0, each issued when in_ready allows.
  - Required: out_code 00,00,00 with out_error 0 and out_value 1.0, 2.0, 3.0.
  - Required: 4th element's pe_proceed1/2/3 = 1.0/2.0/3.0, and out_code = pe_code.
- Busy stall:
  - Stimulus: stream 5 accepted at edge 10, then held in_valid on stream 5.
  - Required: in_ready low through edge 54; next accept at edge 55; out_valid at cycle after edge 54.
- Full throughput:
  - Stimulus: 48 streams round-robin for 480 cycles.
  - Required: in_ready never low; 480 out_valid pulses in issue order with matching out_stream.
- Restart:
  - Stimulus: stream 3 with history {1,2,3} gets in_first with data 9.0.
  - Required: pe_proceed* = 0; out_code 00; out_value 9.0.
- Reset mid-flight:
  - Stimulus: assert rst 20 cycles after 10 accepts.
  - Required: all outputs 0 immediately; no out_valid afterwards; in_ready high for all streams after release.
- Same-cycle accept and writeback:
  - Stimulus: stream 1 writeback coincides with stream 2 accept carrying in_first.
  - Required: stream 1 history shifted and stream 2 history cleared, both in that cycle.

Source files
------------

// File: rtl/fit_1d_scheduler.sv
// Interleaving scheduler for the 1D curve-fitting predictor: per-stream history,
// fixed-latency tag pipeline and writeback of reconstructed values.
module fit_1d_scheduler #(
  parameter int DATA_W      = 32,
  parameter int CODE_W      = 2,
  parameter int NUM_STREAMS = 48,
  parameter int SID_W       = 6,
  parameter int PE_LATENCY  = 44
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SID_W-1:0]  in_stream,
  input  logic              in_first,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] pe_data_in,
  output logic [DATA_W-1:0] pe_proceed1,
  output logic [DATA_W-1:0] pe_proceed2,
  output logic [DATA_W-1:0] pe_proceed3,
  input  logic [CODE_W-1:0] pe_code,
  input  logic [DATA_W-1:0] pe_prediction,
  input  logic [DATA_W-1:0] pe_real_error,
  output logic              out_valid,
  output logic [SID_W-1:0]  out_stream,
  output logic [CODE_W-1:0] out_code,
  output logic [DATA_W-1:0] out_value,
  output logic [DATA_W-1:0] out_error
);

  logic [DATA_W-1:0] hist1_q [NUM_STREAMS];
  logic [DATA_W-1:0] hist1_d [NUM_STREAMS];
  logic [DATA_W-1:0] hist2_q [NUM_STREAMS];
  logic [DATA_W-1:0] hist2_d [NUM_STREAMS];
  logic [DATA_W-1:0] hist3_q [NUM_STREAMS];
  logic [DATA_W-1:0] hist3_d [NUM_STREAMS];
  logic [1:0]        cnt_q   [NUM_STREAMS];
  logic [1:0]        cnt_d   [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] busy_q, busy_d;

  logic [PE_LATENCY-1:0] tag_valid_q, tag_valid_d;
  logic [PE_LATENCY-1:0] tag_warm_q, tag_warm_d;
  logic [SID_W-1:0]      tag_stream_q [PE_LATENCY];
  logic [SID_W-1:0]      tag_stream_d [PE_LATENCY];
  logic [DATA_W-1:0]     tag_data_q   [PE_LATENCY];
  logic [DATA_W-1:0]     tag_data_d   [PE_LATENCY];

  logic [DATA_W-1:0] pe_data_in_q, pe_data_in_d;
  logic [DATA_W-1:0] pe_proceed1_q, pe_proceed1_d;
  logic [DATA_W-1:0] pe_proceed2_q, pe_proceed2_d;
  logic [DATA_W-1:0] pe_proceed3_q, pe_proceed3_d;

  logic              out_valid_q, out_valid_d;
  logic [SID_W-1:0]  out_stream_q, out_stream_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic [DATA_W-1:0] out_value_q, out_value_d;
  logic [DATA_W-1:0] out_error_q, out_error_d;

  logic              stream_ok;
  logic              accept;
  logic              accept_warm;
  logic              wb_valid;
  logic              wb_warm;
  logic [SID_W-1:0]  wb_sid;
  logic [DATA_W-1:0] wb_value;

  assign stream_ok = (int'(in_stream) < NUM_STREAMS);
  assign in_ready  = stream_ok & ~busy_q[in_stream] & ~rst;
  assign accept    = in_valid & in_ready;

  // The oldest tag stage lines up with the predictor's result for that issue.
  assign wb_valid = tag_valid_q[PE_LATENCY-1];
  assign wb_warm  = tag_warm_q[PE_LATENCY-1];
  assign wb_sid   = tag_stream_q[PE_LATENCY-1];
  assign wb_value = wb_warm ? tag_data_q[PE_LATENCY-1] : pe_prediction;

  always_comb begin
    hist1_d       = hist1_q;
    hist2_d       = hist2_q;
    hist3_d       = hist3_q;
    cnt_d         = cnt_q;
    busy_d        = busy_q;
    pe_data_in_d  = pe_data_in_q;
    pe_proceed1_d = pe_proceed1_q;
    pe_proceed2_d = pe_proceed2_q;
    pe_proceed3_d = pe_proceed3_q;
    out_valid_d   = 1'b0;
    out_stream_d  = out_stream_q;
    out_code_d    = out_code_q;
    out_value_d   = out_value_q;
    out_error_d   = out_error_q;
    accept_warm   = 1'b0;

    if (wb_valid) begin
      hist1_d[wb_sid] = hist2_q[wb_sid];
      hist2_d[wb_sid] = hist3_q[wb_sid];
      hist3_d[wb_sid] = wb_value;
      cnt_d[wb_sid]   = (cnt_q[wb_sid] == 2'd3) ? 2'd3 : cnt_q[wb_sid] + 2'd1;
      busy_d[wb_sid]  = 1'b0;
      out_valid_d     = 1'b1;
      out_stream_d    = wb_sid;
      out_code_d      = wb_warm ? '0 : pe_code;
      out_value_d     = wb_value;
      out_error_d     = wb_warm ? '0 : pe_real_error;
    end

    // Writeback never targets the accepted stream: that one is still busy.
    if (accept) begin
      pe_data_in_d = in_data;
      busy_d[in_stream] = 1'b1;
      if (in_first) begin
        pe_proceed1_d      = '0;
        pe_proceed2_d      = '0;
        pe_proceed3_d      = '0;
        hist1_d[in_stream] = '0;
        hist2_d[in_stream] = '0;
        hist3_d[in_stream] = '0;
        cnt_d[in_stream]   = 2'd0;
        accept_warm        = 1'b1;
      end else begin
        pe_proceed1_d = hist1_q[in_stream];
        pe_proceed2_d = hist2_q[in_stream];
        pe_proceed3_d = hist3_q[in_stream];
        accept_warm   = (cnt_q[in_stream] != 2'd3);
      end
    end

    tag_valid_d     = {tag_valid_q[PE_LATENCY-2:0], accept};
    tag_warm_d      = {tag_warm_q[PE_LATENCY-2:0], accept_warm};
    tag_stream_d[0] = in_stream;
    tag_data_d[0]   = in_data;
    for (int i = 1; i < PE_LATENCY; i++) begin
      tag_stream_d[i] = tag_stream_q[i-1];
      tag_data_d[i]   = tag_data_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        hist1_q[i] <= '0;
        hist2_q[i] <= '0;
        hist3_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      busy_q      <= '0;
      tag_valid_q <= '0;
      tag_warm_q  <= '0;
      for (int i = 0; i < PE_LATENCY; i++) begin
        tag_stream_q[i] <= '0;
        tag_data_q[i]   <= '0;
      end
      pe_data_in_q  <= '0;
      pe_proceed1_q <= '0;
      pe_proceed2_q <= '0;
      pe_proceed3_q <= '0;
      out_valid_q   <= 1'b0;
      out_stream_q  <= '0;
      out_code_q    <= '0;
      out_value_q   <= '0;
      out_error_q   <= '0;
    end else begin
      hist1_q       <= hist1_d;
      hist2_q       <= hist2_d;
      hist3_q       <= hist3_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      tag_valid_q   <= tag_valid_d;
      tag_warm_q    <= tag_warm_d;
      tag_stream_q  <= tag_stream_d;
      tag_data_q    <= tag_data_d;
      pe_data_in_q  <= pe_data_in_d;
      pe_proceed1_q <= pe_proceed1_d;
      pe_proceed2_q <= pe_proceed2_d;
      pe_proceed3_q <= pe_proceed3_d;
      out_valid_q   <= out_valid_d;
      out_stream_q  <= out_stream_d;
      out_code_q    <= out_code_d;
      out_value_q   <= out_value_d;
      out_error_q   <= out_error_d;
    end
  end

  assign pe_data_in  = pe_data_in_q;
  assign pe_proceed1 = pe_proceed1_q;
  assign pe_proceed2 = pe_proceed2_q;
  assign pe_proceed3 = pe_proceed3_q;
  assign out_valid   = out_valid_q;
  assign out_stream  = out_stream_q;
  assign out_code    = out_code_q;
  assign out_value   = out_value_q;
  assign out_error   = out_error_q;

endmodule

// File: tb/tb_fit_1d_scheduler.sv
// Scoreboard bench for fit_1d_scheduler: the bench plays the predictor, a stream-level
// model predicts proceeds/results, and a separate monitor checks every out_valid pulse.
module tb_fit_1d_scheduler;
  localparam int DW = 32;
  localparam int NS = 48;
  localparam int L  = 44;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    in_stream = '0;
  logic          in_first = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [DW-1:0] pe_data_in, pe_proceed1, pe_proceed2, pe_proceed3;
  logic [1:0]    pe_code = '0;
  logic [DW-1:0] pe_prediction = '0;
  logic [DW-1:0] pe_real_error = '0;
  logic          out_valid;
  logic [5:0]    out_stream;
  logic [1:0]    out_code;
  logic [DW-1:0] out_value, out_error;

  always #5 clk = ~clk;

  fit_1d_scheduler #(.DATA_W(32), .CODE_W(2), .NUM_STREAMS(NS), .SID_W(6), .PE_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_stream(in_stream),
    .in_first(in_first), .in_data(in_data), .pe_data_in(pe_data_in),
    .pe_proceed1(pe_proceed1), .pe_proceed2(pe_proceed2), .pe_proceed3(pe_proceed3),
    .pe_code(pe_code), .pe_prediction(pe_prediction), .pe_real_error(pe_real_error),
    .out_valid(out_valid), .out_stream(out_stream), .out_code(out_code),
    .out_value(out_value), .out_error(out_error)
  );

  typedef struct {
    logic [5:0]  sid;
    logic [1:0]  code;
    logic [31:0] value;
    logic [31:0] err;
    int          at;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] pred;
    logic [31:0] err;
    logic [1:0]  code;
  } pe_t;

  exp_t sb_q[$];
  pe_t  pe_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int edge_n  = 0;

  // Stream-level reference: last three reconstructed values, warm-up count, release edge.
  logic [31:0] m_hist [NS][3];
  int          m_cnt  [NS];
  int          m_rel  [NS];
  logic [31:0] e_data = '0, e_p1 = '0, e_p2 = '0, e_p3 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: out_valid for stream %0d with nothing outstanding (edge %0d)",
                 out_stream, edge_n);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out_stream", 32'(out_stream), 32'(e.sid));
        chk("out_code", 32'(out_code), 32'(e.code));
        chk("out_value", out_value, e.value);
        chk("out_error", out_error, e.err);
        chk("out_edge", edge_n, e.at);
        n_out++;
        $display("[TB] result stream=%0d code=%0d value=%08h error=%08h edge=%0d",
                 out_stream, out_code, out_value, out_error, edge_n);
      end
    end
  end

  task automatic model_clear();
    for (int s = 0; s < NS; s++) begin
      m_hist[s][0] = '0; m_hist[s][1] = '0; m_hist[s][2] = '0;
      m_cnt[s] = 0;
      m_rel[s] = 0;
    end
  endtask

  // One clock: drive inputs while clk is low, predict the edge, then check pe_* at the next negedge.
  task automatic step(input logic v, input int s, input logic f, input logic [31:0] d, output logic acc);
    pe_t         p;
    exp_t        e;
    logic [31:0] pred, err, val;
    logic [1:0]  code;
    logic        warm;
    in_valid  = v;
    in_stream = 6'(s);
    in_first  = f;
    in_data   = d;
    if (pe_q.size() > 0 && pe_q[0].due == edge_n + 1) begin
      p = pe_q.pop_front();
      pe_prediction = p.pred;
      pe_code       = p.code;
      pe_real_error = p.err;
    end else begin
      pe_prediction = $urandom;
      pe_code       = 2'($urandom);
      pe_real_error = $urandom;
    end
    #1;
    chk("in_ready", 32'(in_ready), 32'(edge_n >= m_rel[s]));
    acc = v && in_ready;
    if (acc) begin
      pred = $urandom;
      err  = $urandom;
      code = 2'($urandom);
      if (f) begin
        m_hist[s][0] = '0; m_hist[s][1] = '0; m_hist[s][2] = '0;
        m_cnt[s] = 0;
      end
      e_data = d;
      e_p1 = m_hist[s][0];
      e_p2 = m_hist[s][1];
      e_p3 = m_hist[s][2];
      warm = (m_cnt[s] < 3);
      val  = warm ? d : pred;
      e.sid = 6'(s);
      e.code = warm ? 2'b00 : code;
      e.value = val;
      e.err = warm ? 32'h0 : err;
      e.at = edge_n + 1 + L;
      sb_q.push_back(e);
      p.due = edge_n + 1 + L;
      p.pred = pred;
      p.err = err;
      p.code = code;
      pe_q.push_back(p);
      m_hist[s][0] = m_hist[s][1];
      m_hist[s][1] = m_hist[s][2];
      m_hist[s][2] = val;
      if (m_cnt[s] < 3) m_cnt[s]++;
      m_rel[s] = edge_n + 1 + L;
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    chk("pe_data_in", pe_data_in, e_data);
    chk("pe_proceed1", pe_proceed1, e_p1);
    chk("pe_proceed2", pe_proceed2, e_p2);
    chk("pe_proceed3", pe_proceed3, e_p3);
  endtask

  task automatic issue(input int s, input logic f, input logic [31:0] d, output int at);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      step(1'b1, s, f, d, acc);
      tries++;
    end
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: stream %0d not accepted within 200 cycles", s);
    end
    at = edge_n;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, NS-1), 1'b0, $urandom, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_stream", 32'(out_stream), 0);
    chk("rst_out_code", 32'(out_code), 0);
    chk("rst_out_value", out_value, 0);
    chk("rst_out_error", out_error, 0);
    chk("rst_pe_data_in", pe_data_in, 0);
    chk("rst_pe_proceed1", pe_proceed1, 0);
    chk("rst_pe_proceed2", pe_proceed2, 0);
    chk("rst_pe_proceed3", pe_proceed3, 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    sb_q.delete();
    pe_q.delete();
    model_clear();
    e_data = '0; e_p1 = '0; e_p2 = '0; e_p3 = '0;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      edge_n++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   a1, a2, stalls, n0;
    logic acc;
    #2;
    do_reset();
    idle(2);

    // Warm-up on stream 0
    issue(0, 1'b1, 32'h3f800000, a1);
    issue(0, 1'b0, 32'h40000000, a1);
    issue(0, 1'b0, 32'h40400000, a1);
    issue(0, 1'b0, 32'h40800000, a1);
    chk("warm_p1", pe_proceed1, 32'h3f800000);
    chk("warm_p2", pe_proceed2, 32'h40000000);
    chk("warm_p3", pe_proceed3, 32'h40400000);

    // Busy stall: hold in_valid on stream 5 until it is accepted again
    idle(3);
    issue(5, 1'b1, $urandom, a1);
    issue(5, 1'b0, $urandom, a2);
    chk("reissue_gap", a2 - a1, L + 1);

    // Full throughput round-robin
    idle(L + 2);
    n0 = n_out;
    stalls = 0;
    for (int i = 0; i < 480; i++) begin
      step(1'b1, i % NS, ($urandom_range(0, 7) == 0), $urandom, acc);
      if (!acc) stalls++;
    end
    in_valid = 1'b0;
    idle(L + 2);
    chk("tp_stalls", stalls, 0);
    chk("tp_results", n_out - n0, 480);

    // Restart stream 3 after building history
    issue(3, 1'b1, 32'h3f800000, a1);
    issue(3, 1'b0, 32'h40000000, a1);
    issue(3, 1'b0, 32'h40400000, a1);
    issue(3, 1'b1, 32'h41100000, a1);
    chk("restart_p1", pe_proceed1, 0);
    chk("restart_p2", pe_proceed2, 0);
    chk("restart_p3", pe_proceed3, 0);

    // Same-cycle writeback (stream 1) and first-accept (stream 2)
    issue(2, 1'b1, $urandom, a1);
    issue(2, 1'b0, $urandom, a1);
    issue(2, 1'b0, $urandom, a1);
    idle(L + 2);
    issue(1, 1'b0, $urandom, a1);
    idle(L - 1);
    step(1'b1, 2, 1'b1, $urandom, acc);
    chk("same_cycle_accept", 32'(acc), 1);
    chk("same_cycle_edge", edge_n, a1 + L);
    in_valid = 1'b0;
    issue(1, 1'b0, $urandom, a1);
    issue(2, 1'b0, $urandom, a1);

    // Reset with ten elements in flight
    idle(L + 2);
    for (int k = 0; k < 10; k++) step(1'b1, 10 + k, 1'b0, $urandom, acc);
    in_valid = 1'b0;
    idle(20);
    do_reset();
    idle(L + 5);
    for (int s = 0; s < NS; s++) step(1'b0, s, 1'b0, $urandom, acc);

    // Random mixed traffic
    for (int i = 0; i < 300; i++)
      step(($urandom_range(0, 3) != 0), $urandom_range(0, NS-1), ($urandom_range(0, 5) == 0), $urandom, acc);
    in_valid = 1'b0;
    idle(L + 3);
    chk("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
